legv8_data_mem_responder: RTL and testbench
===========================================

Name: legv8_data_mem_responder

Overview:
- Responder end of the LEGv8 datapath memory bus.
- Answers the datapath's memory requests (data, address, regW, EN_MEM) with a programmable wait-state count.
- Uses a four-phase EN_MEM/mem_ready handshake.
- Holds 64-bit doublewords and reports misaligned or out-of-range accesses.
- Instantiated beside the datapath in the complete-system top level.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit words stored (power of two, ≥2).
- WAIT_CYCLES, 2, clock edges from request accept to response (0..15).
- ADDR_BASE, 32'h0000_0000, byte address of word 0 (8-byte aligned).

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
- data  inout  64  bidirectional data bus: datapath drives write data; responder drives read data.
- address  in  32  byte address from datapath.
- regW  in  1  access direction: 1 = write, 0 = read.
- EN_MEM  in  1  request strobe; held high by datapath until mem_ready seen.
- mem_ready  out  1  acknowledge; high in DONE state only.
- mem_err  out  1  access fault flag; valid only while mem_ready = 1.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (reset = 0 at edge):
  - state := IDLE; wait counter := 0; mem_ready = 0; mem_err = 0; data = high-Z.
  - Storage contents are not altered.
  - Reset during BUSY or DONE aborts the access; no write is committed.
- IDLE, EN_MEM = 1 at an edge → accept the request:
  - Latch address, regW, and data (data only when regW = 1) into request registers.
  - Compute the fault condition: address[2:0] != 0, OR address < ADDR_BASE, OR address ≥ ADDR_BASE + 8*DEPTH_WORDS.
  - If fault → DONE with mem_err := 1, regardless of WAIT_CYCLES.
  - Else if WAIT_CYCLES = 0 → DONE; perform the write commit at this same edge.
  - Else → BUSY with counter := WAIT_CYCLES.
- BUSY:
  - If EN_MEM = 0 → IDLE (abort, no commit).
  - Else if counter = 1 → DONE; commit the latched write at this edge when regW latched = 1.
  - Else counter decrements.
- Latency: request accepted at edge k → mem_ready high after edge k+WAIT_CYCLES.
- DONE:
  - mem_ready = 1; mem_err = latched fault.
  - Stay in DONE while EN_MEM = 1.
  - EN_MEM = 0 → IDLE, and mem_ready/mem_err drop after that edge.
  - No new request is accepted until IDLE is reached, so one access per handshake.
- Word index = (address − ADDR_BASE) >> 3, truncated to clog2(DEPTH_WORDS) bits. Bits above the index are covered by the range check, so there is no wrap-around.
- Bus drive: data is driven with mem[index] only when state = DONE, latched regW = 0, and mem_err = 0. It is high-Z at all other times, including a faulted read.
- Read data reflects the array at DONE entry. Writes are full 64-bit only; no byte enables.
- Changing regW, address, or data during BUSY/DONE has no effect; latched values are used.

Decomposition:
- Package legv8_mem_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - WORD_W = 64, ADDR_W = 32, BYTE_SHIFT = 3.
  - Function for the index width (clog2).
- Sub-module legv8_mem_array:
  - DEPTH_WORDS × 64 storage, synchronous write (we, waddr, wdata), asynchronous read (raddr → rdata).
  - The responder holds the FSM, request registers, fault logic, and tri-state driver.

Test Plan:
- Write then read, WAIT_CYCLES = 2:
  - Write 64'hDEAD_BEEF_0123_4567 to address 0x18 → mem_ready high exactly 2 edges after accept, mem_err = 0.
  - Drop EN_MEM, then read 0x18 → data = 64'hDEAD_BEEF_0123_4567 while mem_ready = 1, high-Z after EN_MEM drops.
- Misaligned address: read of 0x1C → mem_ready after 1 edge, mem_err = 1, data stays high-Z.
- Out-of-range address: write to ADDR_BASE + 8*DEPTH_WORDS (0x800) → mem_err = 1; word 0 and word 255 unchanged on readback.
- Abort mid-BUSY: write 64'h1 to 0x20, drop EN_MEM one edge after accept → no mem_ready; readback of 0x20 returns its prior value (64'h0 if never written).
- Reset mid-BUSY: reset = 0 for one edge during a write → state IDLE, mem_ready = 0, write not committed.
- WAIT_CYCLES = 0 build: read 0x0 after writing 64'h5A → mem_ready after the first edge following EN_MEM; holding EN_MEM high 3 cycles keeps mem_ready high with no second access.

Source files
------------

// File: rtl/legv8_data_mem_responder_pkg.sv
// Shared types and constants for the LEGv8 data-memory responder slice.
package legv8_mem_pkg;

  localparam int WORD_W     = 64;
  localparam int ADDR_W     = 32;
  localparam int BYTE_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int indexWidth(input int depthWords);
    return (depthWords > 1) ? $clog2(depthWords) : 1;
  endfunction

endpackage

// File: rtl/legv8_data_mem_responder_if.sv
// Request/acknowledge signals between the LEGv8 datapath and its data memory.
interface legv8_data_mem_responder_if;
  import legv8_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              regW;
  logic              EN_MEM;
  logic              mem_ready;
  logic              mem_err;

  modport master (
    output address,
    output regW,
    output EN_MEM,
    input  mem_ready,
    input  mem_err
  );

  modport slave (
    input  address,
    input  regW,
    input  EN_MEM,
    output mem_ready,
    output mem_err
  );

endinterface

// File: rtl/legv8_data_mem_responder_array.sv
// Doubleword storage: synchronous write port, asynchronous read port, no reset.
module legv8_mem_array
  import legv8_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = indexWidth(DEPTH_WORDS)
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/legv8_data_mem_responder.sv
// Memory responder for the LEGv8 datapath: four-phase EN_MEM/mem_ready handshake,
// programmable wait states, alignment/range fault reporting, tri-state read bus.
module legv8_data_mem_responder
  import legv8_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 256,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  inout  wire  [WORD_W-1:0]       data,
  legv8_data_mem_responder_if.slave bus
);

  localparam int IDX_W = indexWidth(DEPTH_WORDS);
  // One bit wider than the address so the end of a window at the top of the map cannot wrap.
  localparam logic [ADDR_W:0] LIMIT =
    {1'b0, ADDR_BASE} + ((ADDR_W + 1)'(DEPTH_WORDS) << BYTE_SHIFT);

  state_t             r_state;
  state_t             w_nextState;
  logic [3:0]         r_count;
  logic               r_regW;
  logic               r_fault;
  logic [IDX_W-1:0]   r_index;
  logic [WORD_W-1:0]  r_wdata;

  logic               w_fault;
  logic [ADDR_W-1:0]  w_offset;
  logic [IDX_W-1:0]   w_index;
  logic               w_accept;
  logic               w_we;
  logic               w_drive;
  logic [IDX_W-1:0]   w_waddr;
  logic [WORD_W-1:0]  w_wdata;
  logic [WORD_W-1:0]  w_rdata;

  assign w_fault  = (bus.address[BYTE_SHIFT-1:0] != '0) ||
                    (bus.address < ADDR_BASE) ||
                    ({1'b0, bus.address} >= LIMIT);
  assign w_offset = bus.address - ADDR_BASE;
  assign w_index  = IDX_W'(w_offset >> BYTE_SHIFT);
  assign w_accept = (r_state == IDLE) && bus.EN_MEM;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.EN_MEM) begin
          w_nextState = (w_fault || (WAIT_CYCLES == 0)) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!bus.EN_MEM) begin
          w_nextState = IDLE;
        end else if (r_count == 4'd1) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (!bus.EN_MEM) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Writes are gated by reset so an access aborted by reset never reaches the array.
  always_comb begin
    bus.mem_ready = 1'b0;
    bus.mem_err   = 1'b0;
    w_we          = 1'b0;
    w_drive       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_we = reset && bus.EN_MEM && bus.regW && !w_fault && (WAIT_CYCLES == 0);
      end
      BUSY: begin
        w_we = reset && bus.EN_MEM && r_regW && (r_count == 4'd1);
      end
      DONE: begin
        bus.mem_ready = 1'b1;
        bus.mem_err   = r_fault;
        w_drive       = !r_regW && !r_fault;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
      r_regW  <= 1'b0;
      r_fault <= 1'b0;
      r_index <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_count <= 4'(WAIT_CYCLES);
      r_regW  <= bus.regW;
      r_fault <= w_fault;
      r_index <= w_index;
      if (bus.regW) begin
        r_wdata <= data;
      end
    end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // A zero-wait write commits on the accept edge, before the request registers load.
  assign w_waddr = (r_state == IDLE) ? w_index : r_index;
  assign w_wdata = (r_state == IDLE) ? data : r_wdata;

  legv8_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clock(clock),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(r_index),
    .o_rdata(w_rdata)
  );

  assign data = w_drive ? w_rdata : 'z;

endmodule

// File: tb/tb_legv8_data_mem_responder.sv
// Randomised scoreboard bench for legv8_data_mem_responder: a WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 instance, each compared against a plain word-array memory model.
module tb_legv8_data_mem_responder;
  import legv8_mem_pkg::*;

  localparam int                DEPTH_A = 256;
  localparam int                WAIT_A  = 2;
  localparam logic [ADDR_W-1:0] BASE_A  = 32'h0000_0000;
  localparam int                DEPTH_Z = 16;
  localparam int                WAIT_Z  = 0;
  localparam logic [ADDR_W-1:0] BASE_Z  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] FLOAT   = '1;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_ABORT  = 1;
  localparam int MODE_RESET  = 2;

  typedef struct {
    bit                sel;
    bit                fault;
    logic [WORD_W-1:0] rdata;
    int                readyCycle;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  legv8_data_mem_responder_if busA();
  legv8_data_mem_responder_if busZ();

  wire  [WORD_W-1:0] dataA;
  wire  [WORD_W-1:0] dataZ;
  logic [WORD_W-1:0] tbDataA;
  logic [WORD_W-1:0] tbDataZ;
  logic              tbDrvA;
  logic              tbDrvZ;

  // An undriven bus reads as all ones, which is how high-Z is observed.
  assign dataA = tbDrvA ? tbDataA : 'z;
  assign dataZ = tbDrvZ ? tbDataZ : 'z;
  pullup (dataA);
  pullup (dataZ);

  legv8_data_mem_responder #(
    .DEPTH_WORDS(DEPTH_A),
    .WAIT_CYCLES(WAIT_A),
    .ADDR_BASE  (BASE_A)
  ) dutA (
    .clock(clock),
    .reset(reset),
    .data (dataA),
    .bus  (busA)
  );

  legv8_data_mem_responder #(
    .DEPTH_WORDS(DEPTH_Z),
    .WAIT_CYCLES(WAIT_Z),
    .ADDR_BASE  (BASE_Z)
  ) dutZ (
    .clock(clock),
    .reset(reset),
    .data (dataZ),
    .bus  (busZ)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  bit   monitorOn = 1'b0;
  bit   prevReady [2];

  logic [WORD_W-1:0] modelA [DEPTH_A];
  logic [WORD_W-1:0] modelZ [DEPTH_Z];

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, got, want);
    end
  endtask

  task automatic check64(input string name, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic rdyOf(input bit sel);
    return sel ? busZ.mem_ready : busA.mem_ready;
  endfunction

  function automatic logic [WORD_W-1:0] modelRead(input bit sel, input int idx);
    if (sel) return modelZ[idx];
    return modelA[idx];
  endfunction

  task automatic modelWrite(input bit sel, input int idx, input logic [WORD_W-1:0] value);
    if (sel) modelZ[idx] = value;
    else     modelA[idx] = value;
  endtask

  task automatic setReq(input bit sel, input logic en, input logic w, input logic [ADDR_W-1:0] addr,
                        input logic drv, input logic [WORD_W-1:0] d);
    if (sel) begin
      busZ.EN_MEM = en; busZ.regW = w; busZ.address = addr; tbDrvZ = drv; tbDataZ = d;
    end else begin
      busA.EN_MEM = en; busA.regW = w; busA.address = addr; tbDrvA = drv; tbDataA = d;
    end
  endtask

  // Monitor: pops the oldest expected response on each rising mem_ready.
  task automatic checkOutput(input bit sel, input logic rdy, input logic err, input logic [WORD_W-1:0] bus);
    exp_t  e;
    string tag;
    tag = sel ? "Z" : "A";
    if (rdy && !prevReady[sel]) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ready_%s: got mem_ready=1 expected 0 (no access outstanding)", tag);
      end else begin
        e = expQ.pop_front();
        checkInt({"resp_port_", tag}, int'(sel), int'(e.sel));
        checkInt({"latency_", tag}, cycle, e.readyCycle);
        checkBit({"mem_err_", tag}, err, e.fault);
        check64({"rdata_", tag}, bus, e.rdata);
      end
    end else if (!rdy && prevReady[sel]) begin
      checkBit({"release_err_", tag}, err, 1'b0);
      check64({"release_data_", tag}, bus, FLOAT);
    end
    prevReady[sel] = rdy;
  endtask

  always @(negedge clock) begin
    if (monitorOn) begin
      checkOutput(1'b0, busA.mem_ready, busA.mem_err, dataA);
      checkOutput(1'b1, busZ.mem_ready, busZ.mem_err, dataZ);
    end
  end

  // One full handshake; the model decides fault, latency and read data from address rules.
  task automatic applyStimulus(input bit sel, input bit isWrite, input logic [ADDR_W-1:0] addr,
                               input logic [WORD_W-1:0] wdata, input int holdExtra, input int mode);
    exp_t   e;
    bit     fault;
    int     idx;
    int     n;
    longint a;
    longint base;
    longint depth;
    int     waitC;
    depth = sel ? DEPTH_Z : DEPTH_A;
    base  = sel ? longint'(BASE_Z) : longint'(BASE_A);
    waitC = sel ? WAIT_Z : WAIT_A;
    a     = longint'(addr);
    fault = ((a % 8) != 0) || (a < base) || (a >= base + 8 * depth);
    idx   = fault ? 0 : int'((a - base) / 8);

    @(negedge clock);
    setReq(sel, 1'b1, isWrite, addr, isWrite, wdata);
    if (mode == MODE_NORMAL) begin
      e.sel        = sel;
      e.fault      = fault;
      e.rdata      = (!isWrite && !fault) ? modelRead(sel, idx) : FLOAT;
      e.readyCycle = cycle + 1 + (fault ? 0 : waitC);
      expQ.push_back(e);
      if (isWrite && !fault) modelWrite(sel, idx, wdata);
    end

    @(posedge clock);
    #1;
    setReq(sel, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0, '0);

    if (mode == MODE_NORMAL) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!rdyOf(sel) && n < 40);
      checkBit("ready_seen", rdyOf(sel), 1'b1);
      if (!rdyOf(sel)) expQ.delete();
      for (int h = 0; h < holdExtra; h++) begin
        @(negedge clock);
        checkBit("ready_hold", rdyOf(sel), 1'b1);
      end
      setReq(sel, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clock);
    end else if (mode == MODE_ABORT) begin
      @(negedge clock);
      setReq(sel, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (WAIT_A + 4) @(negedge clock);
      checkBit("abort_no_ready", rdyOf(sel), 1'b0);
    end else begin
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkBit("midreset_ready", busA.mem_ready, 1'b0);
      checkBit("midreset_err", busA.mem_err, 1'b0);
      check64("midreset_data", dataA, FLOAT);
      reset = 1'b1;
      setReq(sel, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (WAIT_A + 4) @(negedge clock);
      checkBit("midreset_no_ready", rdyOf(sel), 1'b0);
    end
  endtask

  initial begin
    bit                sel;
    int                depth;
    int                kind;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr;

    reset = 1'b0;
    setReq(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (3) @(negedge clock);
    checkBit("reset_ready_A", busA.mem_ready, 1'b0);
    checkBit("reset_err_A", busA.mem_err, 1'b0);
    check64("reset_data_A", dataA, FLOAT);
    checkBit("reset_ready_Z", busZ.mem_ready, 1'b0);
    check64("reset_data_Z", dataZ, FLOAT);
    reset = 1'b1;
    @(negedge clock);
    prevReady[0] = 1'b0;
    prevReady[1] = 1'b0;
    monitorOn    = 1'b1;

    // Bring every word to a known zero through the normal write path.
    for (int i = 0; i < DEPTH_A; i++) applyStimulus(1'b0, 1'b1, ADDR_W'(i * 8), '0, 0, MODE_NORMAL);
    for (int i = 0; i < DEPTH_Z; i++) applyStimulus(1'b1, 1'b1, ADDR_W'(i * 8), '0, 0, MODE_NORMAL);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 1'b1, 32'h18, 64'hDEAD_BEEF_0123_4567, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b0, 32'h18, '0, 1, MODE_NORMAL);
    applyStimulus(1'b0, 1'b0, 32'h1C, '0, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b1, 32'h7F8, 64'h0F0F_0000_FFFF_1234, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b1, 32'h800, 64'hFFFF_0000_AAAA_5555, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b0, 32'h7F8, '0, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b1, 32'h20, 64'h1, 0, MODE_ABORT);
    applyStimulus(1'b0, 1'b0, 32'h20, '0, 0, MODE_NORMAL);
    applyStimulus(1'b0, 1'b1, 32'h28, 64'h1234_5678_9ABC_DEF0, 0, MODE_RESET);
    applyStimulus(1'b0, 1'b0, 32'h28, '0, 0, MODE_NORMAL);
    applyStimulus(1'b1, 1'b1, 32'h0, 64'h5A, 0, MODE_NORMAL);
    applyStimulus(1'b1, 1'b0, 32'h0, '0, 3, MODE_NORMAL);
    applyStimulus(1'b1, 1'b0, 32'h80, '0, 0, MODE_NORMAL);

    $display("[TB] randomised accesses");
    for (int t = 0; t < 120; t++) begin
      sel   = ($urandom_range(0, 3) == 0);
      depth = sel ? DEPTH_Z : DEPTH_A;
      base  = sel ? BASE_Z : BASE_A;
      kind  = $urandom_range(0, 9);
      if (kind == 0) begin
        addr = base + ADDR_W'($urandom_range(0, depth - 1) * 8 + $urandom_range(1, 7));
      end else if (kind == 1) begin
        addr = base + ADDR_W'(depth * 8 + 8 * $urandom_range(0, 15));
      end else if (kind == 2) begin
        addr = 32'hFFFF_FFF8;
      end else if (kind < 6) begin
        addr = base + ADDR_W'((depth - 1 - $urandom_range(0, 3)) * 8);
      end else begin
        addr = base + ADDR_W'($urandom_range(0, 5) * 8);
      end
      applyStimulus(sel, $urandom_range(0, 1) == 1, addr, {$urandom, $urandom},
                    $urandom_range(0, 2), MODE_NORMAL);
    end

    repeat (4) @(negedge clock);
    checkInt("scoreboard_drain", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clock);
    $display("[TB] FAIL watchdog: got still running after 50000 cycles expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
